// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage execute unit. Single-cycle integer ALU plus an iterative
// multiply/divide unit, with valid/ready handshakes on both input and output.
// The result and zero flag are registered.
// Optional build macro: ALU_MDU_FAST_MUL_EN. When it is defined, multiplies use
// one combinational 2*XLEN product and take one cycle. When it is not defined,
// multiplies use a radix-2 shift-add loop. The divider always iterates.
module alu_mdu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SH_W = $clog2(XLEN);
`ifdef ALU_MDU_FAST_MUL_EN
  localparam bit MUL_SINGLE = 1'b1;
`else
  localparam bit MUL_SINGLE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [1:0]          f3_reg;      // low funct3 bits select the half or quotient/remainder
  logic                neg_q_reg;   // product / quotient needs negation
  logic                neg_r_reg;   // remainder needs negation (dividend sign)
  logic [XLEN-1:0]     mcand_reg;   // multiplicand magnitude or divisor magnitude
  logic [2*XLEN-1:0]   prod_reg;    // mul: {acc, multiplier}; div: {rem, dividend/quotient}

  logic                accept;
  logic                last_iter;
  logic [SH_W-1:0]     shamt;
  logic [XLEN-1:0]     alu_res;
  logic                sgn1, sgn2, s1, s2;
  logic [XLEN-1:0]     mag1, mag2;
  logic                div_zero, div_ovf, div_special;
  logic [XLEN-1:0]     div_special_res;
  logic [XLEN-1:0]     fast_mul_res;
  logic                single_cycle;
  logic [XLEN-1:0]     imm_res;

  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_prod_next;
  logic [2*XLEN-1:0]   mul_signed;
  logic [XLEN-1:0]     mul_final;

  logic [XLEN:0]       div_shift;
  logic [XLEN:0]       div_trial;
  logic                div_ok;
  logic [XLEN-1:0]     div_rem_next;
  logic [XLEN-1:0]     div_quo_next;
  logic [XLEN-1:0]     div_final;

  assign accept    = in_valid & in_ready & ~flush;
  assign in_ready  = (state_reg == IDLE) | ((state_reg == DONE) & out_ready);
  assign out_valid = (state_reg == DONE);
  assign last_iter = (cnt_reg == CNT_W'(XLEN - 1));
  assign shamt     = in2[SH_W-1:0];

  // Base ALU: combinational result that is registered at the accept edge
  always_comb begin
    alu_res = '0;
    case (op[3:0])
      4'd0:    alu_res = in1 + in2;
      4'd8:    alu_res = in1 - in2;
      4'd1:    alu_res = in1 << shamt;
      4'd2:    alu_res = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
      4'd3:    alu_res = {{(XLEN-1){1'b0}}, (in1 < in2)};
      4'd4:    alu_res = in1 ^ in2;
      4'd5:    alu_res = in1 >> shamt;
      4'd13:   alu_res = $signed(in1) >>> shamt;
      4'd6:    alu_res = in1 | in2;
      4'd7:    alu_res = in1 & in2;
      default: alu_res = '0;
    endcase
  end

  // Operand signedness per M-op: divides use funct3[0] (0 = signed);
  // for multiplies, MULH is s*s and MULHSU is s*u
  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    if (op[2]) begin
      sgn1 = ~op[0];
      sgn2 = ~op[0];
    end else begin
      sgn1 = (op[1:0] == 2'b01) | (op[1:0] == 2'b10);
      sgn2 = (op[1:0] == 2'b01);
    end
  end

  assign s1   = in1[XLEN-1] & sgn1;
  assign s2   = in2[XLEN-1] & sgn2;
  assign mag1 = s1 ? (~in1 + 1'b1) : in1;
  assign mag2 = s2 ? (~in2 + 1'b1) : in2;

  // A zero divisor and signed overflow bypass the iteration loop.
  // Their result is formed at the accept edge.
  assign div_zero    = (in2 == '0);
  assign div_ovf     = ~op[0] & (in1 == {1'b1, {(XLEN-1){1'b0}}}) & (in2 == '1);
  assign div_special = div_zero | div_ovf;
  assign div_special_res = op[1] ? (div_zero ? in1 : '0)
                                 : (div_zero ? '1  : in1);

`ifdef ALU_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_mag;
  logic [2*XLEN-1:0] fast_prod;
  assign fast_mag     = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
  assign fast_prod    = (s1 ^ s2) ? (~fast_mag + 1'b1) : fast_mag;
  assign fast_mul_res = (op[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  assign fast_mul_res = '0;
`endif

  // Decide whether the accepted op completes at the accept edge, and with what value
  always_comb begin
    single_cycle = 1'b1;
    imm_res      = alu_res;
    if (op[4]) begin
      if (op[2]) begin
        single_cycle = div_special;
        imm_res      = div_special_res;
      end else begin
        single_cycle = MUL_SINGLE;
        imm_res      = fast_mul_res;
      end
    end
  end

  // One shift-add multiply step. The last step also applies the sign and selects the half.
  always_comb begin
    mul_sum       = {1'b0, prod_reg[2*XLEN-1:XLEN]} + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
    mul_prod_next = {mul_sum, prod_reg[XLEN-1:1]};
    mul_signed    = neg_q_reg ? (~mul_prod_next + 1'b1) : mul_prod_next;
    mul_final     = (f3_reg == 2'b00) ? mul_signed[XLEN-1:0] : mul_signed[2*XLEN-1:XLEN];
  end

  // One restoring divide step. The last step also fixes the quotient and remainder signs.
  always_comb begin
    div_shift    = {prod_reg[2*XLEN-1:XLEN], prod_reg[XLEN-1]};
    div_trial    = div_shift - {1'b0, mcand_reg};
    div_ok       = ~div_trial[XLEN];
    div_rem_next = div_ok ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
    div_quo_next = {prod_reg[XLEN-2:0], div_ok};
    div_final    = f3_reg[1] ? (neg_r_reg ? (~div_rem_next + 1'b1) : div_rem_next)
                             : (neg_q_reg ? (~div_quo_next + 1'b1) : div_quo_next);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next state; flush overrides everything
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (accept) begin
          if (single_cycle)  state_next = DONE;
          else if (op[2])    state_next = DIV;
          else               state_next = MUL;
        end else if ((state_reg == DONE) && out_ready) begin
          state_next = IDLE;
        end
      end
      MUL, DIV: if (last_iter) state_next = DONE;
      default:  state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Datapath: latch operands on accept, step the iterative unit, and write the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      f3_reg    <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      mcand_reg <= '0;
      prod_reg  <= '0;
      result    <= '0;
      zero      <= 1'b1;
    end else if (!flush) begin
      if (accept) begin
        f3_reg    <= op[1:0];
        cnt_reg   <= '0;
        neg_q_reg <= s1 ^ s2;
        neg_r_reg <= s1;
        if (op[2]) begin
          mcand_reg <= mag2;
          prod_reg  <= {{XLEN{1'b0}}, mag1};
        end else begin
          mcand_reg <= mag1;
          prod_reg  <= {{XLEN{1'b0}}, mag2};
        end
        if (single_cycle) begin
          result <= imm_res;
          zero   <= (imm_res == '0);
        end
      end else if (state_reg == MUL) begin
        prod_reg <= mul_prod_next;
        cnt_reg  <= cnt_reg + 1'b1;
        if (last_iter) begin
          result <= mul_final;
          zero   <= (mul_final == '0);
        end
      end else if (state_reg == DIV) begin
        prod_reg <= {div_rem_next, div_quo_next};
        cnt_reg  <= cnt_reg + 1'b1;
        if (last_iter) begin
          result <= div_final;
          zero   <= (div_final == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: table-driven scoreboard bench for alu_mdu (XLEN=32), with hand-written
// sequences for latency, back-pressure, flush and mid-operation reset.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] in1, in2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] v;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  exp_t mon_e;

  alu_mdu #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in1(in1), .in2(in2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Output monitor: pops the scoreboard whenever a result is handed over
  always begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h required=none", result);
      end else begin
        mon_e = exp_q.pop_front();
        txn++;
        $display("txn %0d %s result=%h expected=%h zero=%0d", txn, mon_e.name, result, mon_e.v, zero);
        check({mon_e.name, "_result"}, result, mon_e.v);
        check({mon_e.name, "_zero"}, {31'd0, zero}, {31'd0, (mon_e.v == 32'd0)});
      end
    end
  end

  // Present an op at a negedge and wait (bounded) until it will be accepted
  task automatic issue(input string name, input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e, input bit push,
                       output int waits);
    exp_t x;
    @(negedge clk);
    in_valid = 1'b1; op = o; in1 = a; in2 = b;
    #1;
    waits = 0;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_accept_timeout actual=in_ready_low required=in_ready_high", name);
    end else if (push) begin
      x.name = name;
      x.v = e;
      exp_q.push_back(x);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Cycles from the accept edge until out_valid is seen
  task automatic lat_test(input string name, input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e, input int explat);
    int w;
    int t;
    issue(name, o, a, b, e, 1'b1, w);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    t = 1;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    check({name, "_latency"}, t, explat);
    drain(name);
  endtask

  // Watch for a number of cycles; out_valid must stay low
  task automatic quiet(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    check({name, "_no_output"}, seen, 0);
  endtask

  initial begin
    int w;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = '0; in1 = '0; in2 = '0;
    out_ready = 1'b1;

    vecs.push_back(vec_t'{5'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000}); // ADD
    vecs.push_back(vec_t'{5'h08, 32'h00000005, 32'h00000005, 32'h00000000}); // SUB
    vecs.push_back(vec_t'{5'h0D, 32'h80000000, 32'h00000004, 32'hF8000000}); // SRA
    vecs.push_back(vec_t'{5'h01, 32'h00000001, 32'hFFFFFFFF, 32'h80000000}); // SLL by 31
    vecs.push_back(vec_t'{5'h02, 32'hFFFFFFFF, 32'h00000001, 32'h00000001}); // SLT
    vecs.push_back(vec_t'{5'h03, 32'hFFFFFFFF, 32'h00000001, 32'h00000000}); // SLTU
    vecs.push_back(vec_t'{5'h04, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0}); // XOR
    vecs.push_back(vec_t'{5'h05, 32'h80000000, 32'h00000004, 32'h08000000}); // SRL
    vecs.push_back(vec_t'{5'h06, 32'h12340000, 32'h00005678, 32'h12345678}); // OR
    vecs.push_back(vec_t'{5'h07, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000}); // AND
    vecs.push_back(vec_t'{5'h09, 32'h12345678, 32'h00000001, 32'h00000000}); // undefined
    vecs.push_back(vec_t'{5'h10, 32'h00000003, 32'hFFFFFFFC, 32'hFFFFFFF4}); // MUL 3*-4
    vecs.push_back(vec_t'{5'h11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000}); // MULH -1*-1
    vecs.push_back(vec_t'{5'h13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE}); // MULHU
    vecs.push_back(vec_t'{5'h12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}); // MULHSU
    vecs.push_back(vec_t'{5'h11, 32'h80000000, 32'h80000000, 32'h40000000}); // MULH min*min
    vecs.push_back(vec_t'{5'h14, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD}); // DIV -7/2
    vecs.push_back(vec_t'{5'h16, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF}); // REM -7/2
    vecs.push_back(vec_t'{5'h14, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD}); // DIV 7/-2
    vecs.push_back(vec_t'{5'h16, 32'h00000007, 32'hFFFFFFFE, 32'h00000001}); // REM 7/-2
    vecs.push_back(vec_t'{5'h15, 32'h00000005, 32'h00000000, 32'hFFFFFFFF}); // DIVU x/0
    vecs.push_back(vec_t'{5'h17, 32'h00000005, 32'h00000000, 32'h00000005}); // REMU x/0
    vecs.push_back(vec_t'{5'h14, 32'h00000007, 32'h00000000, 32'hFFFFFFFF}); // DIV x/0
    vecs.push_back(vec_t'{5'h16, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9}); // REM x/0
    vecs.push_back(vec_t'{5'h14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000}); // DIV overflow
    vecs.push_back(vec_t'{5'h16, 32'h80000000, 32'hFFFFFFFF, 32'h00000000}); // REM overflow
    vecs.push_back(vec_t'{5'h15, 32'h00000064, 32'h00000007, 32'h0000000E}); // DIVU 100/7
    vecs.push_back(vec_t'{5'h17, 32'h00000064, 32'h00000007, 32'h00000002}); // REMU 100/7
    vecs.push_back(vec_t'{5'h15, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF}); // DIVU max/1

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table, issued back-to-back
    for (int i = 0; i < vecs.size(); i++)
      issue($sformatf("vec%0d_op%0h", i, vecs[i].op), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].exp, 1'b1, w);
    idle();
    drain("table");

    // Base op directly after a base op: no bubble
    issue("b2b_sub", 5'h08, 32'd5, 32'd5, 32'd0, 1'b1, w);
    issue("b2b_sra", 5'h0D, 32'h80000000, 32'd4, 32'hF8000000, 1'b1, w);
    check("b2b_wait_cycles", w, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    drain("b2b");

    // Latencies
    lat_test("lat_add", 5'h00, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1);
`ifdef ALU_MDU_FAST_MUL_EN
    lat_test("lat_mulh", 5'h11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1);
    lat_test("lat_mulhu", 5'h13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
`else
    lat_test("lat_mulh", 5'h11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    lat_test("lat_mulhu", 5'h13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
`endif
    lat_test("lat_div", 5'h14, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    lat_test("lat_divu0", 5'h15, 32'd5, 32'd0, 32'hFFFFFFFF, 1);

    // Back-pressure: result held and in_ready low until drained
    out_ready = 1'b0;
    issue("stall_divu", 5'h15, 32'd100, 32'd7, 32'd14, 1'b1, w);
    idle();
    begin
      int t = 0;
      #1;
      while (!out_valid && t < 100) begin
        @(negedge clk);
        #1;
        t++;
      end
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        #1;
        check($sformatf("stall%0d_result", i), result, 32'd14);
        check($sformatf("stall%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    drain("stall");

    // Flush around the tenth divide iteration
    issue("flush_div", 5'h14, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, w);
    idle();
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    quiet("flush_div", 40);
    lat_test("post_flush_add", 5'h00, 32'd10, 32'd20, 32'd30, 1);

    // Flush in the same cycle as an accept drops the op
    @(negedge clk);
    in_valid = 1'b1; op = 5'h00; in1 = 32'd1; in2 = 32'd1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    quiet("flush_accept", 5);

    // Reset in the middle of an iterative op
`ifdef ALU_MDU_FAST_MUL_EN
    issue("rst_mid", 5'h15, 32'd100, 32'd7, 32'd0, 1'b0, w);
`else
    issue("rst_mid", 5'h11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, w);
`endif
    idle();
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_result", result, 32'd0);
    check("midrst_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    quiet("midrst", 40);
    lat_test("post_rst_add", 5'h00, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
